// File: rtl/pat_pkg.sv
// Shared definitions for the multi-channel serial pattern detector.
// Holds the parameter defaults, the length-field width derivation and the
// helper that locates a channel's slice inside a packed per-channel bus.
package pat_pkg;

  localparam int unsigned MAXLEN_DEF  = 8;
  localparam int unsigned NUM_PAT_DEF = 2;
  localparam int unsigned CW_DEF      = 8;

  // Width of a length field able to hold 0..maxlen.
  function automatic int unsigned lw_of(input int unsigned maxlen);
    return $clog2(maxlen + 1);
  endfunction

  // Low bit index of channel k in a bus of w-bit channel fields.
  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/pat_chan.sv
// One pattern channel: shadow seq/len/en, fill counter, masked compare
// against the post-shift history, and the registered match pulse.
// Ports:
//   clk, reset      clock, async active-low reset
//   clr, cfg_load   synchronous clear / shadow capture strobes
//   in_valid        a serial bit is accepted at this edge
//   overlap         shadow overlap mode (held at top level)
//   cfg_seq/len/en  this channel's configuration inputs
//   hist_nxt        history as it will be after shifting in the current bit
//   hit             combinational: this edge completes a match
//   out             registered one-cycle match pulse
module pat_chan
  import pat_pkg::*;
#(
  parameter int unsigned MAXLEN = MAXLEN_DEF,
  parameter int unsigned LW     = lw_of(MAXLEN_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              cfg_load,
  input  logic              in_valid,
  input  logic              overlap,
  input  logic [MAXLEN-1:0] cfg_seq,
  input  logic [LW-1:0]     cfg_len,
  input  logic              cfg_en,
  input  logic [MAXLEN-1:0] hist_nxt,
  output logic              hit,
  output logic              out
);

  typedef logic [LW-1:0] lw_t;
  typedef logic [LW:0]   ext_t;

  localparam ext_t MAXL = MAXLEN[LW:0];

  logic [MAXLEN-1:0] seq;
  logic [MAXLEN-1:0] mask;
  lw_t               len;
  lw_t               fill;
  logic              en;
  logic              len_ok;
  logic              fill_ok;
  logic              match;

  always_comb begin
    mask    = ~({MAXLEN{1'b1}} << len);
    len_ok  = (len > lw_t'(1)) && (ext_t'(len) <= MAXL);
    fill_ok = (ext_t'(fill) + ext_t'(1)) >= ext_t'(len);
    match   = en && len_ok && fill_ok && (((hist_nxt ^ seq) & mask) == '0);
    // A bit arriving with cfg_load or clr never completes a match.
    hit     = in_valid && !clr && !cfg_load && match;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq <= '0;
      len <= '0;
      en  <= 1'b0;
    end else if (cfg_load) begin
      seq <= cfg_seq;
      len <= cfg_len;
      en  <= cfg_en;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill <= '0;
    end else if (clr || cfg_load) begin
      fill <= '0;
    end else if (in_valid) begin
      if (match && !overlap) begin
        fill <= '0;
      end else if (ext_t'(fill) < MAXL) begin
        fill <= fill + lw_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out <= 1'b0;
    end else begin
      out <= hit;
    end
  end

endmodule

// File: rtl/pat_multi.sv
// Multi-channel serial pattern detector. A shared MAXLEN-bit history is
// compared each accepted bit against NUM_PAT independently configured
// patterns; each channel pulses out[k] one cycle after a completing bit.
// Ports:
//   clk, reset            clock, async active-low reset
//   in_valid, in          serial bit strobe and data
//   clr                   synchronous clear of history, fills and hit count
//   cfg_load              capture cfg_seq/cfg_len/cfg_en/cfg_overlap
//   cfg_seq, cfg_len,
//   cfg_en, cfg_overlap   configuration inputs (channel k at slice k)
//   out                   per-channel match pulse
//   any_out               OR of out
//   hit_cnt               saturating count of cycles with any_out high
module pat_multi
  import pat_pkg::*;
#(
  parameter  int unsigned MAXLEN  = MAXLEN_DEF,
  parameter  int unsigned NUM_PAT = NUM_PAT_DEF,
  parameter  int unsigned CW      = CW_DEF,
  localparam int unsigned LW      = lw_of(MAXLEN)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      in,
  input  logic                      clr,
  input  logic                      cfg_load,
  input  logic [NUM_PAT*MAXLEN-1:0] cfg_seq,
  input  logic [NUM_PAT*LW-1:0]     cfg_len,
  input  logic [NUM_PAT-1:0]        cfg_en,
  input  logic                      cfg_overlap,
  output logic [NUM_PAT-1:0]        out,
  output logic                      any_out,
  output logic [CW-1:0]             hit_cnt
);

  typedef logic [CW-1:0] cnt_t;

  logic [MAXLEN-1:0]  hist;
  logic [MAXLEN-1:0]  hist_nxt;
  logic               overlap;
  logic [NUM_PAT-1:0] hit;

  assign hist_nxt = {hist[MAXLEN-2:0], in};
  assign any_out  = |out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
    end else if (clr) begin
      hist <= '0;
    end else if (in_valid) begin
      hist <= hist_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overlap <= 1'b0;
    end else if (cfg_load) begin
      overlap <= cfg_overlap;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt <= '0;
    end else if (clr) begin
      hit_cnt <= '0;
    end else if ((|hit) && (hit_cnt != '1)) begin
      hit_cnt <= hit_cnt + cnt_t'(1);
    end
  end

  for (genvar k = 0; k < NUM_PAT; k++) begin : g_chan
    pat_chan #(
      .MAXLEN (MAXLEN),
      .LW     (LW)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr),
      .cfg_load (cfg_load),
      .in_valid (in_valid),
      .overlap  (overlap),
      .cfg_seq  (cfg_seq[slice_lo(k, MAXLEN) +: MAXLEN]),
      .cfg_len  (cfg_len[slice_lo(k, LW) +: LW]),
      .cfg_en   (cfg_en[k]),
      .hist_nxt (hist_nxt),
      .hit      (hit[k]),
      .out      (out[k])
    );
  end

endmodule

// File: tb/tb_pat_multi.sv
// Directed bench for pat_multi: default instance plus a CW=2 instance
// sharing the same stimulus for the saturation case.
module tb_pat_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in;
  logic        clr;
  logic        cfg_load;
  logic [15:0] cfg_seq;
  logic [7:0]  cfg_len;
  logic [1:0]  cfg_en;
  logic        cfg_overlap;
  logic [1:0]  out;
  logic        any_out;
  logic [7:0]  hit_cnt;
  logic [1:0]  out_s;
  logic        any_out_s;
  logic [1:0]  hit_cnt_s;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  pat_multi #(.MAXLEN(8), .NUM_PAT(2), .CW(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .clr(clr),
    .cfg_load(cfg_load), .cfg_seq(cfg_seq), .cfg_len(cfg_len), .cfg_en(cfg_en),
    .cfg_overlap(cfg_overlap), .out(out), .any_out(any_out), .hit_cnt(hit_cnt)
  );

  pat_multi #(.MAXLEN(8), .NUM_PAT(2), .CW(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .clr(clr),
    .cfg_load(cfg_load), .cfg_seq(cfg_seq), .cfg_len(cfg_len), .cfg_en(cfg_en),
    .cfg_overlap(cfg_overlap), .out(out_s), .any_out(any_out_s), .hit_cnt(hit_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    in_valid = 1'b1;
    in       = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [15:0] seq, input logic [7:0] len,
                      input logic [1:0] en, input logic ov, input logic do_clr);
    cfg_seq     = seq;
    cfg_len     = len;
    cfg_en      = en;
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    clr         = do_clr;
    tick();
    cfg_load    = 1'b0;
    clr         = 1'b0;
    cfg_seq     = '1;
    cfg_len     = '1;
    cfg_en      = '1;
    cfg_overlap = ~ov;
  endtask

  // Bits sent MSB first; exp holds out[0] after each bit, same order.
  task automatic run_ch0(input string tag, input logic [15:0] bits,
                         input logic [15:0] exp, input int unsigned n);
    for (int i = int'(n) - 1; i >= 0; i--) begin
      send(bits[i]);
      check($sformatf("%s_b%0d", tag, int'(n) - i), {31'd0, out[0]}, {31'd0, exp[i]});
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in = 1'b0; clr = 1'b0; cfg_load = 1'b0;
    cfg_seq = '0; cfg_len = '0; cfg_en = '0; cfg_overlap = 1'b0;
    repeat (3) tick();
    check("rst_out", {30'd0, out}, 32'd0);
    check("rst_any", {31'd0, any_out}, 32'd0);
    check("rst_hit", {24'd0, hit_cnt}, 32'd0);
    reset = 1'b1;
    tick();

    // No channel enabled after reset: nothing may fire.
    run_ch0("noconf", 16'b0110, 16'b0000, 4);
    check("noconf_hit", {24'd0, hit_cnt}, 32'd0);

    // Overlap, ch0 = 0110 len 4, loaded together with clr.
    load(16'h0006, 8'h04, 2'b01, 1'b1, 1'b1);
    check("cfgclr_hit", {24'd0, hit_cnt}, 32'd0);
    run_ch0("ovl", 16'b01101100110, 16'b00010010001, 11);
    check("ovl_hit", {24'd0, hit_cnt}, 32'd3);

    // Non-overlap, same stream.
    load(16'h0006, 8'h04, 2'b01, 1'b0, 1'b1);
    run_ch0("novl", 16'b01101100110, 16'b00010000001, 11);
    check("novl_hit", {24'd0, hit_cnt}, 32'd2);

    // Two channels: ch0 = 0110 len 4, ch1 = 10 len 2.
    load(16'h0206, 8'h24, 2'b11, 1'b1, 1'b1);
    send(1'b0); check("two_b1", {30'd0, out}, 32'd0);
    send(1'b1); check("two_b2", {30'd0, out}, 32'd0);
    send(1'b1); check("two_b3", {30'd0, out}, 32'd0);
    send(1'b0); check("two_b4", {30'd0, out}, 32'd3);
    check("two_any", {31'd0, any_out}, 32'd1);
    check("two_hit", {24'd0, hit_cnt}, 32'd1);

    // Gapped input, same config, after a plain clr.
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_hit", {24'd0, hit_cnt}, 32'd0);
    send(1'b0); tick(); check("gap1", {30'd0, out}, 32'd0);
    send(1'b1); tick(); check("gap2", {30'd0, out}, 32'd0);
    send(1'b1); tick(); check("gap3", {30'd0, out}, 32'd0);
    send(1'b0); check("gap_last", {30'd0, out}, 32'd3);
    tick();     check("gap_after", {30'd0, out}, 32'd0);
    check("gap_hit", {24'd0, hit_cnt}, 32'd1);

    // clr after the third bit of 0110 restarts the pattern.
    load(16'h0006, 8'h04, 2'b01, 1'b1, 1'b1);
    run_ch0("preclr", 16'b011, 16'b000, 3);
    clr = 1'b1; in_valid = 1'b1; in = 1'b0; tick(); clr = 1'b0; in_valid = 1'b0;
    check("clr_out", {30'd0, out}, 32'd0);
    run_ch0("postclr", 16'b0110, 16'b0001, 4);

    // cfg_load mid-pattern: history kept, but len fresh bits needed.
    load(16'h0006, 8'h04, 2'b01, 1'b1, 1'b1);
    run_ch0("precfg", 16'b01, 16'b00, 2);
    load(16'h0006, 8'h04, 2'b01, 1'b1, 1'b0);
    run_ch0("postcfg", 16'b100110, 16'b000001, 6);

    // Saturation: ch1 = 10 len 2, five matches.
    load(16'h0200, 8'h20, 2'b10, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send(1'b1);
      send(1'b0);
      check($sformatf("sat_pulse%0d", i), {30'd0, out}, 32'd2);
    end
    check("sat_hit8", {24'd0, hit_cnt}, 32'd5);
    check("sat_hit2", {30'd0, hit_cnt_s}, 32'd3);

    // Reset asserted while a pulse is high clears outputs at once.
    load(16'h0006, 8'h04, 2'b01, 1'b1, 1'b1);
    run_ch0("prerst", 16'b0110, 16'b0001, 4);
    reset = 1'b0;
    #1;
    check("arst_out", {30'd0, out}, 32'd0);
    check("arst_any", {31'd0, any_out}, 32'd0);
    check("arst_hit", {24'd0, hit_cnt}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    run_ch0("postrst", 16'b0110, 16'b0000, 4);
    check("postrst_any", {31'd0, any_out}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pat_multi.md
PAT_MULTI -- requirements
Module: pat_multi

Interface
REQ-001 The block SHALL have parameter MAXLEN, default 8, giving the maximum pattern length in bits (legal range 2..32).
REQ-002 The block SHALL have parameter NUM_PAT, default 2, giving the number of independent pattern channels (legal range 1..8).
REQ-003 The block SHALL have parameter CW, default 8, giving the width of the hit counter.
REQ-004 The block SHALL have the derived constant LW = clog2(MAXLEN+1).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the serial bit on `in` is accepted at this edge.
REQ-008 The block SHALL have port in, input, 1 bit: the serial data bit.
REQ-009 The block SHALL have port clr, input, 1 bit: synchronous clear of history, fill counters and hit counter.
REQ-010 The block SHALL have port cfg_load, input, 1 bit: captures cfg_seq, cfg_len, cfg_en and cfg_overlap into the shadow registers.
REQ-011 The block SHALL have port cfg_seq, input, NUM_PAT*MAXLEN bits: the patterns, with channel k at [k*MAXLEN +: MAXLEN].
REQ-012 The block SHALL have port cfg_len, input, NUM_PAT*LW bits: the per-channel pattern length.
REQ-013 The block SHALL have port cfg_en, input, NUM_PAT bits: the per-channel enable.
REQ-014 The block SHALL have port cfg_overlap, input, 1 bit: 1 selects overlapping matches, 0 selects non-overlapping.
REQ-015 The block SHALL have port out, output, NUM_PAT bits: a per-channel one-cycle match pulse.
REQ-016 The block SHALL have port any_out, output, 1 bit: the OR of `out`.
REQ-017 The block SHALL have port hit_cnt, output, CW bits: a saturating count of cycles in which any_out is asserted.

Function
REQ-018 The block SHALL use only the registered shadow configuration for matching; cfg_* inputs SHALL be ignored except at a cfg_load edge.
REQ-019 The history register SHALL be MAXLEN bits; on an accepted bit it SHALL update as hist <= {hist[MAXLEN-2:0], in}.
REQ-020 The first-received bit of a pattern SHALL correspond to seq_k[len_k-1], and the last-received bit to seq_k[0].
REQ-021 Each channel k SHALL hold a fill counter fill_k (0..MAXLEN) that increments on each accepted bit and saturates at MAXLEN.
REQ-022 Channel k SHALL match on an accepted bit when all of the following hold: en_k=1, 1 < len_k <= MAXLEN, fill_k+1 >= len_k, and the new history satisfies hist'[len_k-1:0] == seq_k[len_k-1:0].
REQ-023 out[k] SHALL be registered and SHALL be high for exactly the one cycle following the edge that accepts the completing bit; latency is 1 clock.
REQ-024 Channel k SHALL be treated as disabled, with out[k] never asserting, when len_k is 0, 1, or greater than MAXLEN.
REQ-025 In overlap mode, fill_k SHALL continue after a match; in non-overlap mode, fill_k SHALL be set to 0 on the accepting edge of a match, so the next match needs len_k fresh bits.
REQ-026 When in_valid=0, hist, fill_k and hit_cnt SHALL hold, and out SHALL be 0 on the next cycle.
REQ-027 On a cfg_load edge, the shadow registers SHALL update and all fill_k SHALL be set to 0, while hist is preserved; a bit accepted on that same edge SHALL be shifted into hist but SHALL neither match nor count toward fill.
REQ-028 On a clr edge, hist, all fill_k, out and hit_cnt SHALL be set to 0 and any bit on that edge SHALL be discarded; clr SHALL take priority over in_valid.
REQ-029 clr and cfg_load asserted together SHALL both take effect.
REQ-030 hit_cnt SHALL increment by 1 on each edge that sets any_out, and SHALL saturate at 2^CW-1 with no wrap.
REQ-031 Multiple channels matching on the same bit SHALL each assert their out bit, and hit_cnt SHALL increment by only 1.

Reset
REQ-032 While reset=0, the block SHALL asynchronously clear hist, all fill_k, out, any_out and hit_cnt to 0.
REQ-033 While reset=0, the block SHALL asynchronously clear the shadow registers to en=0, len=0, seq=0 and overlap=0.
REQ-034 After the reset release, no output SHALL assert until a cfg_load has enabled a channel.

Structure
REQ-035 A shared package pat_pkg SHALL hold the MAXLEN/NUM_PAT/CW defaults, the LW derivation function, and the channel slice-index helper.
REQ-036 One sub-module, pat_chan, SHALL be instantiated NUM_PAT times; each instance SHALL hold its shadow seq/len/en, its fill counter, the masked compare, and the registered out bit.
REQ-037 The top level SHALL hold hist, the overlap shadow, any_out and hit_cnt.

Verification
REQ-038 Overlap scenario: ch0 seq=0110, len=4, overlap=1; stream 0,1,1,0,1,1,0,0,1,1,0 -> out[0] pulses after bits 4, 7 and 11, and hit_cnt=3.
REQ-039 Non-overlap scenario: the same stream with overlap=0 -> out[0] pulses after bits 4 and 11 only, and hit_cnt=2.
REQ-040 Two-channel scenario: ch0=0110 (len 4), ch1=10 (len 2); stream 0,1,1,0 -> out=2'b11 after bit 4, and hit_cnt increments by 1.
REQ-041 Gapped-input scenario: the bits 0,1,1,0 are separated by in_valid=0 gaps -> a single pulse after the last valid bit, and out=0 during the gaps.
REQ-042 Mid-stream disruption scenario: clr after the 3rd bit of 0110, then 0,1,1,0 -> exactly one pulse, after the 4th post-clr bit; cfg_load mid-pattern -> no match until len_k new bits have been accepted.
REQ-043 Reset/saturation scenario: reset asserted mid-pattern -> outputs 0 immediately; with CW=2 and 5 matches -> hit_cnt=3.
